// File: rtl/aes_dec_keysched.sv
`default_nettype none
// ============================================================================
//  Module   : aes_dec_keysched
//  Function : AES-128 key expansion that emits round keys in decryption
//             order (10 down to 0), walking the schedule backwards in place.
//  Revision : 1.0  initial release
// ============================================================================
module aes_dec_keysched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        logic [10:0] off;
        off = 11'd2047 - {b, 3'b000};
        return c_sbox[off -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic         r_valid;
    logic         r_done;

    state_t       w_state_nxt;
    logic [127:0] w_key_nxt;
    logic [3:0]   w_rnd_nxt;
    logic         w_valid_nxt;
    logic         w_done_nxt;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_sb_in, w_rot, w_sub, w_mix;
    logic [127:0] w_fwd, w_bwd;
    logic [31:0]  w_n0;

    assign w_w0 = r_key[31:0];
    assign w_w1 = r_key[63:32];
    assign w_w2 = r_key[95:64];
    assign w_w3 = r_key[127:96];

    // Going backwards, the S-box input is the recovered previous w3 (n3^n2),
    // so the one S-box array serves both directions through this mux.
    assign w_sb_in = (r_state == EMIT) ? (w_w3 ^ w_w2) : w_w3;
    assign w_rot   = {w_sb_in[7:0], w_sb_in[31:8]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign w_sub[8*i +: 8] = sbox_lookup(w_rot[8*i +: 8]);
    end

    // The round counter doubles as the Rcon index in both directions.
    assign w_mix = w_sub ^ {24'h000000, rcon(r_rnd)};

    assign w_n0  = w_w0 ^ w_mix;
    assign w_fwd = {w_w3 ^ w_w2 ^ w_w1 ^ w_n0,
                    w_w2 ^ w_w1 ^ w_n0,
                    w_w1 ^ w_n0,
                    w_n0};

    assign w_bwd = {w_w3 ^ w_w2,
                    w_w2 ^ w_w1,
                    w_w1 ^ w_w0,
                    w_n0};

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_rnd_nxt   = r_rnd;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_key_nxt   = key;
                    w_rnd_nxt   = 4'd1;
                    w_state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                w_key_nxt = w_fwd;
                if (r_rnd == 4'd10) begin
                    w_rnd_nxt   = 4'd10;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = EMIT;
                end else begin
                    w_rnd_nxt = r_rnd + 4'd1;
                end
            end
            EMIT: begin
                // The done cycle is still spent in EMIT so a start seen
                // alongside the done pulse cannot be captured.
                if (r_done) begin
                    w_state_nxt = IDLE;
                end else if (r_valid && rk_ready) begin
                    if (r_rnd != 4'd0) begin
                        w_key_nxt = w_bwd;
                        w_rnd_nxt = r_rnd - 4'd1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_rnd   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_rnd   <= w_rnd_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign rk       = r_key;
    assign rk_idx   = r_rnd;
    assign rk_valid = r_valid;
    assign done     = r_done;
    assign busy     = (r_state == EXPAND) || ((r_state == EMIT) && !r_done);

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_keysched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_dec_keysched
//  Function : self-checking bench for aes_dec_keysched using an independent
//             key-expansion model with an algebraically derived S-box.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_dec_keysched;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    localparam logic [127:0] c_fips_key = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] c_fips_r10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] c_fips_r1  = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] c_zero_r10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

    int n_tests;
    int n_fail;

    logic [7:0]   sb     [256];
    logic [7:0]   rc     [11];
    logic [127:0] exp_rk [11];
    logic [127:0] obs_rk [11];

    aes_dec_keysched u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic init_model();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[a] = s;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int r = 2; r <= 10; r++) rc[r] = gmul(rc[r-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[7:0], w[31:8]};
        return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3;
        exp_rk[0] = k;
        for (int r = 1; r <= 10; r++) begin
            w0 = exp_rk[r-1][31:0];   w1 = exp_rk[r-1][63:32];
            w2 = exp_rk[r-1][95:64];  w3 = exp_rk[r-1][127:96];
            w0 = w0 ^ sub_rot(w3) ^ {24'h0, rc[r]};
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            exp_rk[r] = {w3, w2, w1, w0};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rk"},    rk,              128'h0);
        check({tag, "_idx"},   128'(rk_idx),    128'h0);
        check({tag, "_valid"}, 128'(rk_valid),  128'h0);
        check({tag, "_busy"},  128'(busy),      128'h0);
        check({tag, "_done"},  128'(done),      128'h0);
    endtask

    // mode 0: always ready; 1: random stalls; 2: 5-cycle stall at idx 7.
    // noise drives start with a different key throughout the operation.
    task automatic run_key(input logic [127:0] k, input int mode, input bit noise);
        int cyc;
        int stall;
        logic [127:0] hold_rk;
        logic [3:0]   hold_idx;
        model_expand(k);
        key = k; start = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        start = noise;
        key   = noise ? ~k : k;
        check("busy_expand", 128'(busy), 128'h1);
        cyc = 0;
        while (!rk_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 128'(cyc), 128'd10);
        for (int i = 10; i >= 0; i--) begin
            if (mode == 1)                 stall = int'($urandom_range(0, 2));
            else if (mode == 2 && i == 7)  stall = 5;
            else                           stall = 0;
            rk_ready = 1'b0;
            hold_rk  = rk;
            hold_idx = rk_idx;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stall_rk",  rk,           hold_rk);
                check("stall_idx", 128'(rk_idx), 128'(hold_idx));
            end
            rk_ready = 1'b1;
            check("rk_valid", 128'(rk_valid), 128'h1);
            check("rk_idx",   128'(rk_idx),   128'(i));
            check("rk",       rk,             exp_rk[i]);
            obs_rk[i] = rk;
            @(negedge clk);
        end
        rk_ready = 1'b0;
        check("done_pulse",  128'(done),     128'h1);
        check("done_valid",  128'(rk_valid), 128'h0);
        check("done_busy",   128'(busy),     128'h0);
        check("done_rk",     rk,             k);
        @(negedge clk);
        check("done_clear",  128'(done),     128'h0);
        check("idle_busy",   128'(busy),     128'h0);
        start = 1'b0;
        key   = k;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [127:0] rkey;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b0;
        init_model();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_key(c_fips_key, 0, 1'b0);
        check("fips_r10", obs_rk[10], c_fips_r10);
        check("fips_r1",  obs_rk[1],  c_fips_r1);
        check("fips_r0",  obs_rk[0],  c_fips_key);

        run_key(128'h0, 0, 1'b0);
        check("zero_r10", obs_rk[10], c_zero_r10);
        check("zero_r0",  obs_rk[0],  128'h0);

        run_key(c_fips_key, 2, 1'b0);
        check("stall7_r10", obs_rk[10], c_fips_r10);
        run_key(c_fips_key, 1, 1'b0);
        check("rand_r1", obs_rk[1], c_fips_r1);

        // Start held during the whole run and the done cycle, then a real
        // start immediately afterwards.
        run_key(c_fips_key, 0, 1'b1);
        run_key(c_fips_key, 0, 1'b0);
        check("after_done_r10", obs_rk[10], c_fips_r10);

        // Reset during the fourth expansion cycle.
        key = c_fips_key; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_expand");
        rst = 1'b0;
        @(negedge clk);
        check("rst_expand_nodone", 128'(done), 128'h0);
        check("rst_expand_idle",   128'(busy), 128'h0);
        run_key(c_fips_key, 0, 1'b0);
        check("rst_expand_r10", obs_rk[10], c_fips_r10);

        // Reset while presenting round key 5.
        key = c_fips_key; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rk_ready = 1'b1;
        cyc = 0;
        while (!(rk_valid && rk_idx == 4'd5) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("emit5_reached", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_emit");
        rst = 1'b0; rk_ready = 1'b0;
        @(negedge clk);
        check("rst_emit_nodone", 128'(done), 128'h0);
        run_key(c_fips_key, 0, 1'b0);
        check("rst_emit_r1", obs_rk[1], c_fips_r1);

        for (int n = 0; n < 1000; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_key(rkey, n % 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_dec_keysched.md
AES_DEC_KEYSCHED -- requirements
Module: aes_dec_keysched

Interface
REQ-001 Clocking/reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to expand key; sampled only in IDLE.
REQ-005 key  input  128  AES-128 cipher key (round-0 key); sampled with start.
REQ-006 rk  output  128  current round key, registered.
REQ-007 rk_idx  output  4  round number of rk (10 down to 0).
REQ-008 rk_valid  output  1  rk/rk_idx valid for transfer.
REQ-009 rk_ready  input  1  consumer accepts rk when rk_valid and rk_ready are both high at a rising edge.
REQ-010 busy  output  1  high in EXPAND and EMIT.
REQ-011 done  output  1  one-cycle pulse after round-0 key transfer.

Function
REQ-012 Packing SHALL be: word i = bits [32i+31:32i] (w0 low); byte 0 of each word = bits [7:0]; FIPS-197 byte stream is little-end-first (byte 0 of key = key[7:0]).
REQ-013 RotWord(w) SHALL be {w[7:0], w[31:8]}; SubWord applies the forward AES S-box to each byte; Rcon(r) for r=1..10 = 01,02,04,08,10,20,40,80,1b,36 in bits [7:0], zero elsewhere.
REQ-014 Forward step fwd(K,r) SHALL be: n0=w0^SubWord(RotWord(w3))^Rcon(r); n1=w1^n0; n2=w2^n1; n3=w3^n2.
REQ-015 Backward step bwd(N,r) SHALL be: w3=n3^n2; w2=n2^n1; w1=n1^n0; w0=n0^SubWord(RotWord(w3))^Rcon(r), so that bwd(fwd(K,r),r)=K.
REQ-016 A single shared S-box array (4 byte lookups) SHALL serve both fwd and bwd; the step type is selected by state.
REQ-017 FSM states SHALL be IDLE, EXPAND, EMIT.
REQ-018 IDLE: on start=1, the block SHALL load the state register with key, set round counter to 1, and enter EXPAND; start=0 keeps IDLE.
REQ-019 EXPAND: each cycle the block SHALL set register=fwd(register,counter) and increment counter; after the step with counter=10, the block SHALL enter EMIT with rk_idx=10.
REQ-020 Latency: with start sampled at edge E0, the block SHALL assert rk_valid after edge E10, with rk=round-10 key.
REQ-021 EMIT: rk_valid=1; rk and rk_idx SHALL hold stable while rk_ready=0 (no timeout).
REQ-022 On transfer with rk_idx>0, the block SHALL set rk=bwd(rk,rk_idx) and decrement rk_idx; rk_valid stays high (back-to-back one key per cycle when rk_ready=1).
REQ-023 On transfer with rk_idx=0, the block SHALL drive rk_valid=0, busy=0, and done=1 for exactly one cycle, then enter IDLE; rk holds the round-0 key.
REQ-024 The block SHALL ignore start while busy=1; a new key is never captured mid-operation.
REQ-025 start asserted in the same cycle as the done pulse SHALL be ignored, because the state is not IDLE yet; start one cycle later SHALL be accepted.
REQ-026 Exactly 11 transfers SHALL occur per start, in order 10,9,...,0; the round-0 key SHALL equal the sampled key bit-exactly.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, rk=0, rk_idx=0, rk_valid=0, busy=0, done=0, and counter=0, overriding all other inputs including start.
REQ-028 rst asserted mid-EXPAND or mid-EMIT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh expansion.

Verification
REQ-029 FIPS-197 key: key=128'h3c4fcf098815f7aba6d2ae2816157e2b, rk_ready=1 -> rk_valid rises 10 cycles after start; the first rk=128'ha60c63b6c80c3fe18925eec9a8f914d0 (idx 10), the second rk=...(idx 9), the idx 1 rk=128'h05766c2a3939a323b12c548817fefaa0, the idx 0 rk equals key, and done pulses once.
REQ-030 Zero key: key=0 -> idx 10 rk=128'h8e188f6fcf51e92311e2923ecb5befb4; idx 0 rk=0.
REQ-031 Backpressure: rk_ready toggled randomly / held low 5 cycles at idx 7 -> rk and rk_idx stable while stalled; the sequence is identical to REQ-029.
REQ-032 start during busy with a different key -> ignored; the output sequence is unchanged; start in the done cycle is ignored, and start one cycle later is accepted.
REQ-033 rst at EXPAND cycle 4 and at EMIT idx 5 -> all outputs reach reset values next cycle with no done pulse; a subsequent start reproduces the REQ-029 sequence.
REQ-034 Random keys (>=1000) -> compare every rk against a reference model of the forward expansion; the idx-0 rk equals key.
